idma_stream_id_tracker: RTL and testbench
=========================================

# idma_stream_id_tracker

Per-stream transfer-ID bookkeeping stage sitting between the 32-bit register front-end arbiter output and the iDMA back-end request port. It passes the front-end request handshake through to the back-end. For every accepted transfer it assigns an incrementing ID per stream and records the stream in an in-order outstanding FIFO. On each back-end completion it retires the oldest entry and advances that stream's done ID, driving the `next_id`/`done_id`/busy status the register file exposes to software.

## Interface
- `NumStreams`, 1: number of streams; legal range 1..16.
- `IdCounterWidth`, 32: width of the ID counters; legal range 2..32.
- `Depth`, 8: maximum outstanding transfers, all streams combined; must be < 2^IdCounterWidth.
- `StreamWidth`, `cf_math_pkg::idx_width(NumStreams)`: dependent; stream index width.
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `stream_idx_i` in StreamWidth: stream of the request on `req_valid_i`.
- `req_valid_i` in 1: request valid from the front-end.
- `req_ready_o` out 1: request ready to the front-end.
- `req_valid_o` out 1: request valid to the back-end.
- `req_ready_i` in 1: request ready from the back-end.
- `rsp_valid_i` in 1: back-end completion pulse/valid (in order).
- `rsp_ready_o` out 1: completion accepted.
- `next_id_o` out NumStreams x IdCounterWidth: ID the next accepted transfer of each stream receives.
- `done_id_o` out NumStreams x IdCounterWidth: ID of the last completed transfer per stream.
- `busy_o` out NumStreams: stream has at least one outstanding transfer.
- `err_o` out 1: one-cycle pulse on a completion arriving with no outstanding transfer.

## Operation
- Request path is combinational:
  - `req_valid_o = req_valid_i & ~full`.
  - `req_ready_o = req_ready_i & ~full`.
  - Accept = `req_valid_i & req_ready_o`.
- On accept:
  - push `stream_idx_i` into the FIFO.
  - `next_id[s] <= next_id[s] + 1`, modulo 2^IdCounterWidth; wraps all-ones -> 0, no skipping.
  - The ID assigned to the transfer is the pre-increment `next_id_o[s]`. The front-end samples it in the same cycle.
- `stream_idx_i` out of range (>= NumStreams): the transfer passes and the FIFO entry is recorded, but no counter changes. A completion that pops such an entry changes no counter.
- `rsp_ready_o = ~empty`. On completion (`rsp_valid_i & rsp_ready_o`):
  - pop the FIFO head h.
  - `done_id[h] <= done_id[h] + 1` (modulo).
- `rsp_valid_i` while empty: completion dropped, `err_o` = 1 for that cycle, no state change.
- `busy_o[s] = (next_id_o[s] != done_id_o[s] + 1)`, modulo arithmetic. Depth < 2^W makes this unambiguous.
- Simultaneous accept and completion:
  - both take effect in the same edge, same or different stream.
  - when full, the pop does not enable a same-cycle push; `req_ready_o` stays low that cycle.
- The block adds no reordering; completions are strictly in issue order.

## Timing
- Reset values:
  - `next_id_o[*]` = 1, `done_id_o[*]` = 0.
  - `busy_o` = 0, `err_o` = 0.
  - FIFO empty, so `rsp_ready_o` = 0.
  - `req_valid_o` and `req_ready_o` follow their inputs (not full).
- Reset mid-operation discards all outstanding entries and restores these values asynchronously.
- Counter, FIFO and `busy_o` updates are visible the cycle after the handshake edge.
- `err_o` is combinational from `rsp_valid_i & empty`.
- `req_valid_o`/`req_ready_o` have zero-cycle latency. `full` and `empty` are registered FIFO state only; they do not depend on the same-cycle pop.

## Structure
- No new package types; ID and stream widths come from parameters. The `busy_o` derivation lives here.
- One sub-module: common_cells `fifo_v3`, DEPTH = Depth, DATA_WIDTH = StreamWidth, FALL_THROUGH = 0, `flush_i` = 0.
- Counters are a flat `NumStreams`-entry register array. `stream_t` and `cnt_width_t` are local parameter types, matching the front-end.

## Test plan
- Reset then idle:
  - `next_id_o` = 1 and `done_id_o` = 0 on all streams.
  - `busy_o` = 0, `rsp_ready_o` = 0.
- NumStreams=2, Depth=4, `req_ready_i` = 1; accept stream 0, 1, 0.
  - Required: `next_id_o` = {3 (s0), 2 (s1)}, busy = 2'b11.
  - Then 3 completions: done = {2, 1} and busy = 0 after the third.
- Accept 4 with Depth=4 -> `req_ready_o` and `req_valid_o` = 0.
  - Completion + request in the same cycle: request not accepted.
  - Next cycle it is accepted.
- IdCounterWidth=2, one stream, 3 accept/complete round trips:
  - `next_id` walks 1 -> 2 -> 3 -> 0.
  - `done_id` walks 0 -> 1 -> 2 -> 3.
  - busy = 0 at each idle point.
- `rsp_valid_i` with empty FIFO -> `err_o` pulses 1 cycle, counters unchanged.
- Assert `rst_ni` low with 3 outstanding -> busy = 0 and counters at reset values immediately. After release, the next accept returns ID 1.

Source files
------------

// File: rtl/idma_stream_id_tracker_pkg.sv
// Shared helpers for the iDMA per-stream transfer-ID tracker.
package idma_stream_id_tracker_pkg;

    // Index width for a select among num_idx items; never below one bit.
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

endpackage

// File: rtl/idma_stream_id_tracker_fifo.sv
// In-order FIFO with registered full/empty; no fall-through, so a pop never frees a same-cycle push.
module idma_stream_id_tracker_fifo #(
    parameter int unsigned Depth     = 8,
    parameter int unsigned DataWidth = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned AddrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth  = $clog2(Depth + 1);

    logic [AddrWidth-1:0] wptr_q, rptr_q;
    logic [CntWidth-1:0]  cnt_q;
    logic [DataWidth-1:0] mem_q [Depth];
    logic                 push_en, pop_en;

    function automatic logic [AddrWidth-1:0] ptr_incr(input logic [AddrWidth-1:0] ptr);
        return (ptr == AddrWidth'(Depth - 1)) ? '0 : ptr + AddrWidth'(1);
    endfunction

    always_comb begin
        full_o  = (cnt_q == CntWidth'(Depth));
        empty_o = (cnt_q == '0);
        push_en = push_i & ~full_o;
        pop_en  = pop_i & ~empty_o;
        data_o  = mem_q[rptr_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_en) wptr_q <= ptr_incr(wptr_q);
            if (pop_en)  rptr_q <= ptr_incr(rptr_q);
            if (push_en && !pop_en)      cnt_q <= cnt_q + CntWidth'(1);
            else if (pop_en && !push_en) cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/idma_stream_id_tracker.sv
// Per-stream transfer-ID bookkeeping between the register front-end and the iDMA back-end.
module idma_stream_id_tracker
    import idma_stream_id_tracker_pkg::*;
#(
    parameter int unsigned NumStreams     = 1,
    parameter int unsigned IdCounterWidth = 32,
    parameter int unsigned Depth          = 8,
    parameter int unsigned StreamWidth    = idx_width(NumStreams)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [StreamWidth-1:0]               stream_idx_i,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    output logic                                 req_valid_o,
    input  logic                                 req_ready_i,
    input  logic                                 rsp_valid_i,
    output logic                                 rsp_ready_o,
    output logic [NumStreams*IdCounterWidth-1:0] next_id_o,
    output logic [NumStreams*IdCounterWidth-1:0] done_id_o,
    output logic [NumStreams-1:0]                busy_o,
    output logic                                 err_o
);

    typedef logic [StreamWidth-1:0]    stream_t;
    typedef logic [IdCounterWidth-1:0] cnt_width_t;

    cnt_width_t next_id_q [NumStreams];
    cnt_width_t done_id_q [NumStreams];
    stream_t    head;
    logic       full, empty, accept, complete;

    always_comb begin
        req_valid_o = req_valid_i & ~full;
        req_ready_o = req_ready_i & ~full;
        accept      = req_valid_i & req_ready_o;
        rsp_ready_o = ~empty;
        complete    = rsp_valid_i & ~empty;
        err_o       = rsp_valid_i & empty;
    end

    idma_stream_id_tracker_fifo #(
        .Depth     (Depth),
        .DataWidth (StreamWidth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .push_i  (accept),
        .data_i  (stream_idx_i),
        .pop_i   (complete),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // Out-of-range stream indices match no counter, so they pass through untracked.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < NumStreams; s++) begin
                next_id_q[s] <= cnt_width_t'(1);
                done_id_q[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < NumStreams; s++) begin
                if (accept && (stream_t'(s) == stream_idx_i)) begin
                    next_id_q[s] <= next_id_q[s] + cnt_width_t'(1);
                end
                if (complete && (stream_t'(s) == head)) begin
                    done_id_q[s] <= done_id_q[s] + cnt_width_t'(1);
                end
            end
        end
    end

    // Depth < 2^IdCounterWidth keeps the modulo distance unambiguous.
    always_comb begin
        for (int unsigned s = 0; s < NumStreams; s++) begin
            next_id_o[s*IdCounterWidth +: IdCounterWidth] = next_id_q[s];
            done_id_o[s*IdCounterWidth +: IdCounterWidth] = done_id_q[s];
            busy_o[s] = (next_id_q[s] != done_id_q[s] + cnt_width_t'(1));
        end
    end

endmodule

// File: tb/tb_idma_stream_id_tracker.sv
// Scoreboard bench: the driver pushes expected outputs from a queue-based model, a monitor compares.
module tb_idma_stream_id_tracker;

    localparam int unsigned NS = 3;
    localparam int unsigned W  = 3;
    localparam int unsigned D  = 4;
    localparam int unsigned SW = 2;
    localparam int          MOD = 1 << W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [SW-1:0]   stream_idx = '0;
    logic            req_valid_in = 1'b0, req_ready_in = 1'b0, rsp_valid = 1'b0;
    logic            req_ready_out, req_valid_out, rsp_ready, err;
    logic [NS*W-1:0] next_id, done_id;
    logic [NS-1:0]   busy;

    idma_stream_id_tracker #(
        .NumStreams     (NS),
        .IdCounterWidth (W),
        .Depth          (D)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .stream_idx_i (stream_idx),
        .req_valid_i  (req_valid_in),
        .req_ready_o  (req_ready_out),
        .req_valid_o  (req_valid_out),
        .req_ready_i  (req_ready_in),
        .rsp_valid_i  (rsp_valid),
        .rsp_ready_o  (rsp_ready),
        .next_id_o    (next_id),
        .done_id_o    (done_id),
        .busy_o       (busy),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            req_valid;
        logic            req_ready;
        logic            rsp_ready;
        logic            err;
        logic [NS*W-1:0] next_id;
        logic [NS*W-1:0] done_id;
        logic [NS-1:0]   busy;
    } exp_t;

    exp_t sb[$];
    int   m_next[NS];
    int   m_done[NS];
    int   m_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_next[i] = 1;
            m_done[i] = 0;
        end
        m_q.delete();
    endtask

    // One cycle: drive away from the edge, record what the DUT must show before the next edge.
    task automatic drive(input bit rst, input bit v, input bit r, input int s, input bit rv);
        exp_t e;
        bit   full, empty;
        int   cnt;
        @(posedge clk);
        #2;
        rst_n        = !rst;
        req_valid_in = v;
        req_ready_in = r;
        stream_idx   = s[SW-1:0];
        rsp_valid    = rv;
        if (rst) model_reset();
        full  = (m_q.size() == D);
        empty = (m_q.size() == 0);
        e.req_valid = v & !full;
        e.req_ready = r & !full;
        e.rsp_ready = !empty;
        e.err       = rv & empty;
        for (int i = 0; i < NS; i++) begin
            e.next_id[i*W +: W] = m_next[i][W-1:0];
            e.done_id[i*W +: W] = m_done[i][W-1:0];
            cnt = 0;
            foreach (m_q[k]) if (m_q[k] == i) cnt++;
            e.busy[i] = (cnt > 0);
        end
        sb.push_back(e);
        if (!rst) begin
            if (rv && !empty) begin
                int h;
                h = m_q.pop_front();
                if (h < NS) m_done[h] = (m_done[h] + 1) % MOD;
            end
            if (v && r && !full) begin
                m_q.push_back(s);
                if (s < NS) m_next[s] = (m_next[s] + 1) % MOD;
            end
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("req_valid_o", 32'(req_valid_out), 32'(e.req_valid));
            check("req_ready_o", 32'(req_ready_out), 32'(e.req_ready));
            check("rsp_ready_o", 32'(rsp_ready), 32'(e.rsp_ready));
            check("err_o", 32'(err), 32'(e.err));
            check("next_id_o", 32'(next_id), 32'(e.next_id));
            check("done_id_o", 32'(done_id), 32'(e.done_id));
            check("busy_o", 32'(busy), 32'(e.busy));
        end
    end

    initial begin
        model_reset();
        repeat (2) drive(1, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 1, 0, 0);
        // Accept streams 0, 1, 0, then three completions.
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 1, 0);
        drive(0, 1, 1, 0, 0);
        repeat (3) drive(0, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 0);
        // Fill to Depth, then completion + request while full.
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 1, 0);
        drive(0, 1, 1, 2, 0);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 1, 1);
        drive(0, 1, 1, 1, 0);
        // Drain, then one completion on an empty FIFO.
        repeat (5) drive(0, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 0);
        // Counter wrap on stream 2.
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 1, 2, 0);
            drive(0, 0, 1, 0, 1);
        end
        // Out-of-range stream and back-end backpressure.
        drive(0, 1, 1, 3, 0);
        drive(0, 1, 0, 1, 0);
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 0);
        // Reset with three outstanding, then the next accept must see ID 1.
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 1, 0);
        drive(0, 1, 1, 0, 0);
        drive(1, 0, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        drive(0, 0, 1, 0, 1);
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 8,
                  int'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 5);
        end
        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
